// File: rtl/bus_word_serializer.sv
// rtl/bus_word_serializer.sv - word FIFO feeding an MSB-first beat serializer
module bus_word_serializer #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     master_valid,
    output logic                     bus_ready,
    input  logic [IN_W-1:0]          master_data,
    output logic                     slave_valid,
    input  logic                     slave_ready,
    output logic [OUT_W-1:0]         slave_data,
    output logic                     slave_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         word_cnt
);
    localparam int NB = IN_W / OUT_W;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [IN_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [IN_W-1:0] sh, sh_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic            push, load, beat, done;

    assign bus_ready   = (level != LW'(DEPTH));
    assign push        = master_valid & bus_ready;
    assign slave_valid = (state == SEND);
    assign slave_last  = slave_valid & (bcnt == BW'(NB - 1));
    assign slave_data  = sh[IN_W-1 -: OUT_W];
    assign fifo_level  = level;
    assign beat        = slave_valid & slave_ready;
    assign done        = beat & slave_last;
    // Reload on the last-beat handshake so consecutive words leave no bubble.
    assign load        = (level != '0) & (!slave_valid | done);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= master_data;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, load})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n = SEND;
                    sh_n    = mem[rd_ptr];
                    bcnt_n  = '0;
                end
            end
            SEND: begin
                if (load) begin
                    sh_n   = mem[rd_ptr];
                    bcnt_n = '0;
                end else if (done) begin
                    state_n = IDLE;
                end else if (beat) begin
                    sh_n   = sh << OUT_W;
                    bcnt_n = bcnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            sh       <= '0;
            bcnt     <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            bcnt  <= bcnt_n;
            if (done) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bus_word_serializer.sv
// tb/tb_bus_word_serializer.sv - directed and randomized scoreboard bench for bus_word_serializer
module tb_bus_word_serializer;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        master_valid;
    logic        slave_ready;
    logic [23:0] master_data;
    logic        bus_ready, slave_valid, slave_last;
    logic [7:0]  slave_data;
    logic [2:0]  fifo_level;
    logic [15:0] word_cnt;
    logic        bus_ready4, slave_valid4, slave_last4;
    logic [7:0]  slave_data4;
    logic [2:0]  fifo_level4;
    logic [3:0]  word_cnt4;

    always #5 clk = ~clk;

    bus_word_serializer #(.IN_W(24), .OUT_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .RSTn(RSTn), .master_valid(master_valid), .bus_ready(bus_ready),
        .master_data(master_data), .slave_valid(slave_valid), .slave_ready(slave_ready),
        .slave_data(slave_data), .slave_last(slave_last), .fifo_level(fifo_level),
        .word_cnt(word_cnt)
    );

    // Narrow-counter copy driven identically, used to observe word_cnt wrap.
    bus_word_serializer #(.IN_W(24), .OUT_W(8), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .RSTn(RSTn), .master_valid(master_valid), .bus_ready(bus_ready4),
        .master_data(master_data), .slave_valid(slave_valid4), .slave_ready(slave_ready),
        .slave_data(slave_data4), .slave_last(slave_last4), .fifo_level(fifo_level4),
        .word_cnt(word_cnt4)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         accepted, delivered, cyc;
    int         first_beat, last_beat, max_level;
    bit         saw_not_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        accepted  = 0;
        delivered = 0;
    endtask

    task automatic push_word(input logic [23:0] w);
        logic [23:0] t;
        for (int i = 0; i < NB; i++) begin
            t = w >> (8 * (NB - 1 - i));
            exp_q.push_back({(i == NB - 1), t[7:0]});
        end
    endtask

    task automatic tick();
        logic       stall, pl;
        logic [7:0] pd;
        logic [8:0] e;
        stall = slave_valid && !slave_ready;
        pd    = slave_data;
        pl    = slave_last;
        if (slave_valid && slave_ready) begin
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 32'(slave_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(slave_data), 32'(e[7:0]));
                check("beat_last", 32'(slave_last), 32'(e[8]));
                if (e[8]) delivered++;
            end
        end
        if (master_valid && bus_ready) begin
            push_word(master_data);
            accepted++;
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (!bus_ready) saw_not_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check("word_cnt", 32'(word_cnt), delivered & 32'hFFFF);
        check("word_cnt4", 32'(word_cnt4), delivered & 32'hF);
        check("level_sum", 32'(fifo_level) + 32'(slave_valid), accepted - delivered);
        if (stall) begin
            check("stall_valid", 32'(slave_valid), 32'd1);
            check("stall_data", 32'(slave_data), 32'(pd));
            check("stall_last", 32'(slave_last), 32'(pl));
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || slave_valid) && n < bound) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [23:0] words [6];
    logic        acc;
    int          idx, guard, base;

    initial begin
        words        = '{24'h001122, 24'h112233, 24'h223344, 24'h334455, 24'h445566, 24'h556677};
        cyc          = 0;
        first_beat   = -1;
        last_beat    = 0;
        max_level    = 0;
        model_reset();

        // Reset held with a word offered.
        RSTn         = 1'b0;
        master_valid = 1'b1;
        master_data  = 24'hABCDEF;
        slave_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(slave_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_ready", 32'(bus_ready), 32'd1);
        check("rst_data", 32'(slave_data), 32'd0);
        check("rst_last", 32'(slave_last), 32'd0);
        RSTn = 1'b1;
        #1;
        check("rel_level", 32'(fifo_level), 32'd0);
        master_valid = 1'b0;

        // Single word latency and beat order.
        master_data  = 24'h001122;
        master_valid = 1'b1;
        tick();
        master_valid = 1'b0;
        check("p2_level", 32'(fifo_level), 32'd1);
        check("p2_idle", 32'(slave_valid), 32'd0);
        tick();
        check("p2_b0_valid", 32'(slave_valid), 32'd1);
        check("p2_b0", 32'(slave_data), 32'h00);
        check("p2_b0_last", 32'(slave_last), 32'd0);
        tick();
        check("p2_b1", 32'(slave_data), 32'h11);
        check("p2_b1_last", 32'(slave_last), 32'd0);
        tick();
        check("p2_b2", 32'(slave_data), 32'h22);
        check("p2_b2_last", 32'(slave_last), 32'd1);
        tick();
        check("p2_done_valid", 32'(slave_valid), 32'd0);
        check("p2_cnt", 32'(word_cnt), 32'd1);

        // Continuous stream: beats must be gapless, FIFO must fill.
        first_beat    = -1;
        max_level     = 0;
        saw_not_ready = 1'b0;
        base          = delivered;
        idx           = 0;
        guard         = 0;
        master_valid  = 1'b1;
        master_data   = words[0];
        while ((idx < 6 || delivered < base + 6) && guard < 200) begin
            acc = master_valid && bus_ready;
            tick();
            guard++;
            if (acc) begin
                idx++;
                if (idx < 6) master_data = words[idx];
                else master_valid = 1'b0;
            end
        end
        check("p3_words", delivered - base, 32'd6);
        check("p3_span", last_beat - first_beat + 1, 32'd18);
        check("p3_max_level", max_level, 32'd4);
        check("p3_saw_full", 32'(saw_not_ready), 32'd1);
        check("p3_cnt", 32'(word_cnt), 32'd7);

        // Backpressure with the head word starting 8'h00.
        slave_ready  = 1'b0;
        master_valid = 1'b1;
        master_data  = 24'h00A1B2;
        repeat (12) begin
            acc = master_valid && bus_ready;
            tick();
            if (acc) master_data = 24'($urandom);
        end
        check("p4_data", 32'(slave_data), 32'h00);
        check("p4_valid", 32'(slave_valid), 32'd1);
        check("p4_level", 32'(fifo_level), 32'd4);
        check("p4_ready", 32'(bus_ready), 32'd0);
        slave_ready  = 1'b1;
        master_valid = 1'b0;
        drain(200);

        // Asynchronous reset in the middle of a word.
        master_data  = 24'h112233;
        master_valid = 1'b1;
        tick();
        master_data  = 24'h556677;
        tick();
        master_valid = 1'b0;
        check("p5_b0", 32'(slave_data), 32'h11);
        tick();
        check("p5_b1", 32'(slave_data), 32'h22);
        RSTn = 1'b0;
        #1;
        check("p5_rst_valid", 32'(slave_valid), 32'd0);
        check("p5_rst_data", 32'(slave_data), 32'd0);
        check("p5_rst_last", 32'(slave_last), 32'd0);
        check("p5_rst_level", 32'(fifo_level), 32'd0);
        check("p5_rst_cnt", 32'(word_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        RSTn         = 1'b1;
        master_data  = 24'h223344;
        master_valid = 1'b1;
        tick();
        master_valid = 1'b0;
        tick();
        check("p5_n0", 32'(slave_data), 32'h22);
        tick();
        check("p5_n1", 32'(slave_data), 32'h33);
        tick();
        check("p5_n2", 32'(slave_data), 32'h44);
        check("p5_n2_last", 32'(slave_last), 32'd1);
        tick();
        check("p5_cnt", 32'(word_cnt), 32'd1);

        // Narrow counter wraps 15 -> 0 -> 1.
        master_valid = 1'b1;
        master_data  = 24'($urandom);
        for (int k = 15; k <= 17; k++) begin
            guard = 0;
            while (delivered < k && guard < 200) begin
                acc = master_valid && bus_ready;
                tick();
                guard++;
                if (acc) master_data = 24'($urandom);
            end
            check("p6_cnt4", 32'(word_cnt4), (k == 15) ? 32'd15 : (k == 16) ? 32'd0 : 32'd1);
        end
        master_valid = 1'b0;
        drain(200);

        // Random traffic against the byte scoreboard.
        repeat (400) begin
            master_valid = 1'($urandom_range(0, 1));
            master_data  = 24'($urandom);
            slave_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        master_valid = 1'b0;
        slave_ready  = 1'b1;
        drain(200);
        check("final_cnt", 32'(word_cnt), delivered & 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
